// File: rtl/cpu24_pkg.sv
// rtl/cpu24_pkg.sv - shared types, widths and PC helper for the 24-bit CPU fetch path
// Contents:
//   XLEN          datapath width (24)
//   word_t        XLEN-bit instruction / address word
//   fetch_state_e fetch FSM states BOOT, RUN, HALTED
//   pc_add        modulo-2^XLEN address add
package cpu24_pkg;

    localparam int XLEN = 24;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // Carry out of bit XLEN-1 is deliberately dropped so the PC wraps silently.
    function automatic word_t pc_add(input word_t a, input word_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - memory, control and IF/ID handshake bundle of the fetch stage
// Signals:
//   MemAddr/MemData          fetch address out, combinational instruction back
//   Redirect/RedirectTarget  branch/jump pulse and new PC
//   Halt                     stop fetching
//   OutValid/OutReady        IF/ID valid/ready handshake
//   OutInst/OutPC/OutPCNext  fetched instruction, its address, address + increment
//   Halted                   fetch stage is parked
// Modports: master = fetch stage, slave = memory/decode/control environment.
interface instruction_fetch_if;
    import cpu24_pkg::*;

    word_t MemAddr;
    word_t MemData;
    logic  Redirect;
    word_t RedirectTarget;
    logic  Halt;
    logic  OutValid;
    logic  OutReady;
    word_t OutInst;
    word_t OutPC;
    word_t OutPCNext;
    logic  Halted;

    modport master (
        output MemAddr,
        input  MemData,
        input  Redirect,
        input  RedirectTarget,
        input  Halt,
        output OutValid,
        input  OutReady,
        output OutInst,
        output OutPC,
        output OutPCNext,
        output Halted
    );

    modport slave (
        input  MemAddr,
        output MemData,
        output Redirect,
        output RedirectTarget,
        output Halt,
        input  OutValid,
        output OutReady,
        input  OutInst,
        input  OutPC,
        input  OutPCNext,
        input  Halted
    );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID valid/ready pipeline register with flush
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   flush                             drop the held entry (wins over capture)
//   capture                           load in_* and mark valid
//   out_ready                         downstream consumes the held entry
//   in_inst, in_pc, in_pc_next        entry to load
//   out_valid, out_inst, out_pc,
//   out_pc_next                       held entry
module if_id_reg
    import cpu24_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  capture,
    input  logic  out_ready,
    input  word_t in_inst,
    input  word_t in_pc,
    input  word_t in_pc_next,
    output logic  out_valid,
    output word_t out_inst,
    output word_t out_pc,
    output word_t out_pc_next
);

    logic  valid_q, valid_d;
    word_t inst_q, inst_d;
    word_t pc_q, pc_d;
    word_t pc_next_q, pc_next_d;

    always_comb begin
        valid_d   = valid_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        if (flush) begin
            // Payload is left as-is; with valid low it is never observed as live.
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d   = 1'b1;
            inst_d    = in_inst;
            pc_d      = in_pc;
            pc_next_d = in_pc_next;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            inst_q    <= '0;
            pc_q      <= '0;
            pc_next_q <= '0;
        end else begin
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_inst    = inst_q;
    assign out_pc      = pc_q;
    assign out_pc_next = pc_next_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, BOOT/RUN/HALTED fetch FSM and IF/ID register
// Parameters:
//   RESET_PC  PC loaded on reset
//   PC_INC    PC advance per fetched instruction
// Ports:
//   Clock     rising-edge clock
//   Reset     asynchronous active-low reset
//   bus       instruction_fetch_if.master (memory, control, IF/ID handshake)
module instruction_fetch
    import cpu24_pkg::*;
#(
    parameter word_t RESET_PC = 24'h000000,
    parameter word_t PC_INC   = 24'h000001
) (
    input  logic                       Clock,
    input  logic                       Reset,
    instruction_fetch_if.master        bus
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pc_plus;
    logic         capture;
    logic         flush;
    logic         out_valid;
    word_t        out_inst;
    word_t        out_pc;
    word_t        out_pc_next;

    assign pc_plus = pc_add(pc_q, PC_INC);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        flush   = 1'b0;
        if (bus.Redirect) begin
            // Redirect overrides Halt and any state, including the BOOT cycle.
            state_d = RUN;
            pc_d    = bus.RedirectTarget;
            flush   = 1'b1;
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (bus.Halt) begin
                        state_d = HALTED;
                    end else if (!out_valid || bus.OutReady) begin
                        capture = 1'b1;
                        pc_d    = pc_plus;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = BOOT;
                    pc_d    = RESET_PC;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // A held entry still drains while halted, since capture is low there.
    if_id_reg u_if_id_reg (
        .clk         (Clock),
        .rst_n       (Reset),
        .flush       (flush),
        .capture     (capture),
        .out_ready   (bus.OutReady),
        .in_inst     (bus.MemData),
        .in_pc       (pc_q),
        .in_pc_next  (pc_plus),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pc_next (out_pc_next)
    );

    assign bus.MemAddr   = pc_q;
    assign bus.OutValid  = out_valid;
    assign bus.OutInst   = out_inst;
    assign bus.OutPC     = out_pc;
    assign bus.OutPCNext = out_pc_next;
    assign bus.Halted    = (state_q == HALTED);

endmodule
